// File: rtl/alu_issue_controller_if.sv
// Command, load, read-back and ALU-side signals of the ALU issue controller.
// The controller uses the slave modport; the command source and ALU use master.
interface alu_issue_controller_if;
    logic        CmdValid;
    logic        CmdReady;
    logic [4:0]  CmdFunSel;
    logic [1:0]  CmdSrcA;
    logic [1:0]  CmdSrcB;
    logic [1:0]  CmdDst;
    logic        CmdWF;
    logic        LoadEn;
    logic [1:0]  LoadSel;
    logic [31:0] LoadData;
    logic [1:0]  RegSel;
    logic [31:0] RegOut;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  FunSel;
    logic        WF;
    logic [31:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic [31:0] Result;
    logic [3:0]  ResultFlags;
    logic        Done;

    modport slave (
        input  CmdValid, CmdFunSel, CmdSrcA, CmdSrcB, CmdDst, CmdWF,
        input  LoadEn, LoadSel, LoadData, RegSel, ALUOut, FlagsOut,
        output CmdReady, RegOut, A, B, FunSel, WF, Result, ResultFlags, Done
    );

    modport master (
        output CmdValid, CmdFunSel, CmdSrcA, CmdSrcB, CmdDst, CmdWF,
        output LoadEn, LoadSel, LoadData, RegSel, ALUOut, FlagsOut,
        input  CmdReady, RegOut, A, B, FunSel, WF, Result, ResultFlags, Done
    );
endinterface

// File: rtl/alu_issue_controller.sv
// Issues one command every three cycles to an external ALU from a 4-entry
// register file, writes the result back and reports the captured flags.
module alu_issue_controller #(
    parameter int NUM_REGS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  fun_sel_q, fun_sel_d;
    logic        wf_q, wf_d;
    logic        cmd_wf_q, cmd_wf_d;
    logic [1:0]  dst_q, dst_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  result_flags_q, result_flags_d;
    logic        done_q, done_d;
    logic        accept;

    assign accept = bus.CmdValid && (state_q == IDLE);

    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        a_d            = a_q;
        b_d            = b_q;
        fun_sel_d      = fun_sel_q;
        wf_d           = 1'b0;
        cmd_wf_d       = cmd_wf_q;
        dst_d          = dst_q;
        result_d       = result_q;
        result_flags_d = result_flags_q;
        done_d         = 1'b0;

        if (bus.LoadEn) begin
            regs_d[bus.LoadSel] = bus.LoadData;
        end

        // Write-back is applied after the direct load so it wins on a collision.
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ISSUE;
                    a_d       = (bus.LoadEn && (bus.LoadSel == bus.CmdSrcA)) ?
                                bus.LoadData : regs_q[bus.CmdSrcA];
                    b_d       = (bus.LoadEn && (bus.LoadSel == bus.CmdSrcB)) ?
                                bus.LoadData : regs_q[bus.CmdSrcB];
                    fun_sel_d = bus.CmdFunSel;
                    dst_d     = bus.CmdDst;
                    cmd_wf_d  = bus.CmdWF;
                    wf_d      = bus.CmdWF;
                end
            end
            ISSUE: begin
                state_d       = WB;
                result_d      = bus.ALUOut;
                regs_d[dst_q] = bus.ALUOut;
            end
            WB: begin
                state_d        = IDLE;
                result_flags_d = bus.FlagsOut;
                done_d         = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            a_q            <= '0;
            b_q            <= '0;
            fun_sel_q      <= '0;
            wf_q           <= 1'b0;
            cmd_wf_q       <= 1'b0;
            dst_q          <= '0;
            result_q       <= '0;
            result_flags_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            regs_q         <= regs_d;
            a_q            <= a_d;
            b_q            <= b_d;
            fun_sel_q      <= fun_sel_d;
            wf_q           <= wf_d;
            cmd_wf_q       <= cmd_wf_d;
            dst_q          <= dst_d;
            result_q       <= result_d;
            result_flags_q <= result_flags_d;
            done_q         <= done_d;
        end
    end

    assign bus.CmdReady    = (state_q == IDLE);
    assign bus.RegOut      = regs_q[bus.RegSel];
    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.FunSel      = fun_sel_q;
    assign bus.WF          = wf_q;
    assign bus.Result      = result_q;
    assign bus.ResultFlags = result_flags_q;
    assign bus.Done        = done_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed bench for alu_issue_controller with a small adder ALU model whose
// flags register updates on edges where WF is high.
module tb_alu_issue_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic       flag_preset_en;
    logic [3:0] flag_preset_val;
    logic [3:0] alu_flags = 4'h0;
    logic [32:0] alu_sum;

    alu_issue_controller_if bus ();

    alu_issue_controller #(.NUM_REGS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder ALU model: combinational sum, flags {Z,C,N,O} registered on WF.
    assign alu_sum      = {1'b0, bus.A} + {1'b0, bus.B};
    assign bus.ALUOut   = alu_sum[31:0];
    assign bus.FlagsOut = alu_flags;

    always @(posedge clk) begin
        if (flag_preset_en) begin
            alu_flags <= flag_preset_val;
        end else if (bus.WF) begin
            alu_flags <= {(alu_sum[31:0] == 32'h0), alu_sum[32], alu_sum[31],
                          (bus.A[31] == bus.B[31]) && (alu_sum[31] != bus.A[31])};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel,
                             input logic [31:0] expected);
        bus.RegSel = sel;
        #1;
        check_output(tag, bus.RegOut, expected);
    endtask

    task automatic apply_stimulus(input logic [4:0] fun, input logic [1:0] src_a,
                                  input logic [1:0] src_b, input logic [1:0] dst,
                                  input logic wf);
        bus.CmdValid  = 1'b1;
        bus.CmdFunSel = fun;
        bus.CmdSrcA   = src_a;
        bus.CmdSrcB   = src_b;
        bus.CmdDst    = dst;
        bus.CmdWF     = wf;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        flag_preset_en  = 1'b0;
        flag_preset_val = 4'h0;
        bus.CmdValid    = 1'b0;
        bus.CmdFunSel   = 5'b0;
        bus.CmdSrcA     = 2'd0;
        bus.CmdSrcB     = 2'd0;
        bus.CmdDst      = 2'd0;
        bus.CmdWF       = 1'b0;
        bus.LoadEn      = 1'b0;
        bus.LoadSel     = 2'd0;
        bus.LoadData    = 32'h0;
        bus.RegSel      = 2'd0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state, with a command and a load offered that must be ignored.
        bus.CmdValid = 1'b1;
        bus.LoadEn   = 1'b1;
        bus.LoadData = 32'hFFFF_FFFF;
        tick();
        tick();
        check_output("rst_cmd_ready", 32'(bus.CmdReady), 32'd1);
        check_output("rst_a", bus.A, 32'h0);
        check_output("rst_b", bus.B, 32'h0);
        check_output("rst_fun_sel", 32'(bus.FunSel), 32'h0);
        check_output("rst_wf", 32'(bus.WF), 32'h0);
        check_output("rst_result", bus.Result, 32'h0);
        check_output("rst_flags", 32'(bus.ResultFlags), 32'h0);
        check_output("rst_done", 32'(bus.Done), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check_reg("rst_regout", 2'(i), 32'h0);
        end
        bus.CmdValid = 1'b0;
        bus.LoadEn   = 1'b0;
        rst_n        = 1'b1;
        tick();
        check_output("post_rst_regout0", bus.RegOut, 32'h0);

        // Load R0/R1 then R2 = R0 + R1 with flag write.
        bus.LoadEn   = 1'b1;
        bus.LoadSel  = 2'd0;
        bus.LoadData = 32'h1234_1234;
        tick();
        bus.LoadSel  = 2'd1;
        bus.LoadData = 32'h4321_4321;
        tick();
        bus.LoadEn = 1'b0;
        check_reg("load_r0", 2'd0, 32'h1234_1234);
        check_reg("load_r1", 2'd1, 32'h4321_4321);
        apply_stimulus(5'b10100, 2'd0, 2'd1, 2'd2, 1'b1);
        tick();
        bus.CmdValid = 1'b0;
        check_output("c1_issue_ready", 32'(bus.CmdReady), 32'd0);
        check_output("c1_issue_a", bus.A, 32'h1234_1234);
        check_output("c1_issue_b", bus.B, 32'h4321_4321);
        check_output("c1_issue_fun", 32'(bus.FunSel), 32'b10100);
        check_output("c1_issue_wf", 32'(bus.WF), 32'd1);
        tick();
        check_output("c1_wb_wf", 32'(bus.WF), 32'd0);
        check_output("c1_wb_result", bus.Result, 32'h5555_5555);
        check_output("c1_wb_done", 32'(bus.Done), 32'd0);
        check_output("c1_wb_a_hold", bus.A, 32'h1234_1234);
        check_reg("c1_wb_r2", 2'd2, 32'h5555_5555);
        tick();
        check_output("c1_done", 32'(bus.Done), 32'd1);
        check_output("c1_flags", 32'(bus.ResultFlags), 32'h0);
        check_output("c1_idle_wf", 32'(bus.WF), 32'd0);
        tick();
        check_output("c1_done_clear", 32'(bus.Done), 32'd0);
        check_output("c1_idle_fun_hold", 32'(bus.FunSel), 32'b10100);

        // Same-edge bypass on operand A, then load colliding with write-back.
        bus.LoadEn   = 1'b1;
        bus.LoadSel  = 2'd1;
        bus.LoadData = 32'h0204_5130;
        tick();
        bus.LoadSel  = 2'd0;
        bus.LoadData = 32'h1234_5678;
        apply_stimulus(5'b10100, 2'd0, 2'd1, 2'd3, 1'b1);
        tick();
        bus.CmdValid = 1'b0;
        bus.LoadSel  = 2'd3;
        bus.LoadData = 32'hDEAD_BEEF;
        check_output("byp_a", bus.A, 32'h1234_5678);
        check_output("byp_b", bus.B, 32'h0204_5130);
        tick();
        bus.LoadEn = 1'b0;
        check_output("byp_result", bus.Result, 32'h1438_A7A8);
        check_reg("byp_wb_wins_r3", 2'd3, 32'h1438_A7A8);
        check_reg("byp_r0_loaded", 2'd0, 32'h1234_5678);
        tick();
        check_output("byp_done", 32'(bus.Done), 32'd1);
        check_output("byp_flags", 32'(bus.ResultFlags), 32'h0);
        tick();

        // Flags preset to 1111; a WF=0 command must leave them untouched.
        flag_preset_en  = 1'b1;
        flag_preset_val = 4'hF;
        tick();
        flag_preset_en = 1'b0;
        apply_stimulus(5'b10100, 2'd0, 2'd1, 2'd3, 1'b0);
        tick();
        bus.CmdValid = 1'b0;
        check_output("nowf_issue_wf", 32'(bus.WF), 32'd0);
        tick();
        check_output("nowf_wb_wf", 32'(bus.WF), 32'd0);
        tick();
        check_output("nowf_done", 32'(bus.Done), 32'd1);
        check_output("nowf_flags", 32'(bus.ResultFlags), 32'hF);
        tick();

        // Two commands with CmdValid held: R0 = R0 + R2, then R1 = R0 + R0.
        apply_stimulus(5'b10100, 2'd0, 2'd2, 2'd0, 1'b1);
        tick();
        apply_stimulus(5'b10100, 2'd0, 2'd0, 2'd1, 1'b1);
        check_output("b2b_issue_ready", 32'(bus.CmdReady), 32'd0);
        check_output("b2b_c1_a", bus.A, 32'h1234_5678);
        tick();
        check_output("b2b_wb_ready", 32'(bus.CmdReady), 32'd0);
        check_output("b2b_c1_result", bus.Result, 32'h6789_ABCD);
        tick();
        check_output("b2b_c1_done", 32'(bus.Done), 32'd1);
        check_output("b2b_ready_with_done", 32'(bus.CmdReady), 32'd1);
        check_output("b2b_c1_flags", 32'(bus.ResultFlags), 32'h0);
        tick();
        bus.CmdValid = 1'b0;
        check_output("b2b_c2_a", bus.A, 32'h6789_ABCD);
        check_output("b2b_c2_done_clear", 32'(bus.Done), 32'd0);
        check_reg("b2b_r0_once", 2'd0, 32'h6789_ABCD);
        tick();
        check_output("b2b_c2_result", bus.Result, 32'hCF13_579A);
        check_reg("b2b_r1", 2'd1, 32'hCF13_579A);
        tick();
        check_output("b2b_c2_done", 32'(bus.Done), 32'd1);
        check_output("b2b_c2_flags", 32'(bus.ResultFlags), 32'h3);
        tick();
        check_output("b2b_end_ready", 32'(bus.CmdReady), 32'd1);
        check_reg("b2b_r0_final", 2'd0, 32'h6789_ABCD);

        // Reset pulse during ISSUE aborts the command.
        apply_stimulus(5'b10100, 2'd0, 2'd1, 2'd2, 1'b1);
        tick();
        bus.CmdValid = 1'b0;
        check_output("abort_issue_wf", 32'(bus.WF), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("abort_ready", 32'(bus.CmdReady), 32'd1);
        check_output("abort_wf", 32'(bus.WF), 32'd0);
        check_output("abort_a", bus.A, 32'h0);
        tick();
        rst_n = 1'b1;
        check_reg("abort_r2", 2'd2, 32'h0);
        tick();
        check_output("abort_done1", 32'(bus.Done), 32'd0);
        check_output("abort_result", bus.Result, 32'h0);
        tick();
        check_output("abort_done2", 32'(bus.Done), 32'd0);
        check_reg("abort_r2_final", 2'd2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_controller.md
ALU_ISSUE_CONTROLLER -- requirements
Module: alu_issue_controller

Interface
REQ-001 Parameters SHALL be NUM_REGS, default 4, operand register count (2-bit selects; only 4 supported).
REQ-002 Clock  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 CmdValid  in  1  command offered.
REQ-005 CmdReady  out  1  command accepted on an edge where CmdValid=1 and CmdReady=1.
REQ-006 CmdFunSel  in  5  ALU function code, forwarded unchanged.
REQ-007 CmdSrcA, CmdSrcB, CmdDst  in  2 each  operand A, operand B and destination register selects.
REQ-008 CmdWF  in  1  flag-write request for this command.
REQ-009 LoadEn  in  1  direct register load strobe.
REQ-010 LoadSel  in  2  register selected for the direct load.
REQ-011 LoadData  in  32  direct load value.
REQ-012 RegSel  in  2  read-back select.
REQ-013 RegOut  out  32  combinational read-back of register RegSel.
REQ-014 A, B  out  32 each  ALU operands (registered).
REQ-015 FunSel  out  5  ALU function select (registered).
REQ-016 WF  out  1  ALU flag-write enable.
REQ-017 ALUOut  in  32  combinational ALU result.
REQ-018 FlagsOut  in  4  ALU registered flags {Z,C,N,O}.
REQ-019 Result  out  32  last captured ALU result.
REQ-020 ResultFlags  out  4  flags captured after the last command.
REQ-021 Done  out  1  one-cycle completion pulse.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WB, with transitions IDLE->ISSUE on accept, ISSUE->WB unconditionally, and WB->IDLE unconditionally.
REQ-023 CmdReady SHALL equal (state==IDLE).
REQ-024 On the accept edge, A<=reg[CmdSrcA], B<=reg[CmdSrcB], FunSel<=CmdFunSel, and CmdWF and CmdDst SHALL be latched.
REQ-025 Same-edge bypass: if LoadEn=1 on the accept edge and LoadSel equals a source select, that operand SHALL take LoadData.
REQ-026 WF SHALL equal the latched CmdWF during ISSUE only and SHALL be 0 in IDLE and WB, so the ALU flags update at most once per command.
REQ-027 A, B and FunSel SHALL hold stable from the accept edge through WB, and SHALL hold their last value in IDLE.
REQ-028 On the ISSUE->WB edge, Result<=ALUOut and reg[Dst]<=ALUOut, sampled before any flag-dependent result change.
REQ-029 On the WB->IDLE edge, ResultFlags<=FlagsOut and Done<=1.
REQ-030 Done SHALL clear on the following edge.
REQ-031 Latency: with accept at edge0, the register write occurs at edge1, and Done is high in the cycle following edge2.
REQ-032 Next accept SHALL be possible at edge3 (one command per 3 cycles), with Done high concurrently.
REQ-033 LoadEn SHALL be honoured in every state, except that when it coincides with the write-back edge to the same register, the write-back SHALL win.
REQ-034 CmdValid while busy SHALL be ignored without loss; the command is taken at the first IDLE edge.
REQ-035 Registers SHALL be 32-bit, with no arithmetic performed in this block.

Reset
REQ-036 Reset=0 SHALL immediately force state=IDLE, all registers=0, A=B=0, FunSel=0, WF=0, Result=0, ResultFlags=0 and Done=0.
REQ-037 CmdReady SHALL read 1 while Reset=0, but no command is accepted and no load occurs while Reset=0.
REQ-038 Reset during ISSUE or WB SHALL abort the command: no write-back, and no Done pulse.

Verification
REQ-039 Scenario: reset -> all outputs 0, CmdReady=1, RegOut=0 for RegSel 0..3.
REQ-040 Scenario: load R0=0x12341234 and R1=0x43214321, then cmd FunSel=10100, SrcA=0, SrcB=1, Dst=2, WF=1 -> WF high exactly one cycle, Result=0x55555555, ResultFlags=0000, Done pulse after edge2, R2=0x55555555.
REQ-041 Scenario: R1=0x02045130, accept with LoadEn=1, LoadSel=0, LoadData=0x12345678, SrcA=0, SrcB=1 -> A=0x12345678, Result=0x1438A7A8.
REQ-042 Scenario: ALU flags preset 1111 and command WF=0 -> WF never asserted, ResultFlags=1111.
REQ-043 Scenario: CmdValid held high for two commands -> CmdReady=0 in ISSUE/WB, each command executed exactly once, second accept coincides with the first Done.
REQ-044 Scenario: Reset pulsed during ISSUE -> state IDLE, Dst register unchanged (0), Done stays 0.
